// File: rtl/hazard_ctrl_if.sv
// Hazard controller signal bundle between the pipeline datapath and
// the hazard/MD controller.
interface hazard_ctrl_if;
  logic [4:0] rsD;
  logic [4:0] rtD;
  logic [4:0] rsE;
  logic [4:0] rtE;
  logic [4:0] writeRegAddrE;
  logic [4:0] writeRegAddrM;
  logic [4:0] writeRegAddrW;
  logic       regWriteE;
  logic       regWriteM;
  logic       regWriteW;
  logic       memToRegE;
  logic       memToRegM;
  logic       branchD;
  logic       mdStartE;
  logic       mdIsDivE;
  logic       mdReadE;

  logic [1:0] forwardAE;
  logic [1:0] forwardBE;
  logic       forwardAD;
  logic       forwardBD;
  logic       stallF;
  logic       stallD;
  logic       stallE;
  logic       flushE;
  logic       mdBusy;
  logic       mdDone;
  logic [1:0] mdState;

  modport master (
    output rsD, rtD, rsE, rtE,
    output writeRegAddrE, writeRegAddrM, writeRegAddrW,
    output regWriteE, regWriteM, regWriteW,
    output memToRegE, memToRegM, branchD,
    output mdStartE, mdIsDivE, mdReadE,
    input  forwardAE, forwardBE, forwardAD, forwardBD,
    input  stallF, stallD, stallE, flushE,
    input  mdBusy, mdDone, mdState
  );

  modport slave (
    input  rsD, rtD, rsE, rtE,
    input  writeRegAddrE, writeRegAddrM, writeRegAddrW,
    input  regWriteE, regWriteM, regWriteW,
    input  memToRegE, memToRegM, branchD,
    input  mdStartE, mdIsDivE, mdReadE,
    output forwardAE, forwardBE, forwardAD, forwardBD,
    output stallF, stallD, stallE, flushE,
    output mdBusy, mdDone, mdState
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Forwarding, load/branch hazard stall/flush and HI/LO mult/div
// sequencer for the five-stage core.
module hazard_ctrl #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  hazard_ctrl_if.slave hz
);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] BUSY = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  logic [1:0]       state;
  logic [1:0]       state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic [CNT_W-1:0] ld_val;

  logic m_live;
  logic w_live;
  logic e_live;
  logic m_hit_ae;
  logic m_hit_be;
  logic w_hit_ae;
  logic w_hit_be;
  logic e_hit_d;
  logic m_hit_d;
  logic lw_stall;
  logic br_stall;
  logic md_stall;

  // r0 is hardwired zero, so it never forwards or stalls
  assign m_live = hz.regWriteM && (hz.writeRegAddrM != 5'd0);
  assign w_live = hz.regWriteW && (hz.writeRegAddrW != 5'd0);
  assign e_live = hz.regWriteE && (hz.writeRegAddrE != 5'd0);

  assign m_hit_ae = m_live && (hz.writeRegAddrM == hz.rsE);
  assign m_hit_be = m_live && (hz.writeRegAddrM == hz.rtE);
  assign w_hit_ae = w_live && (hz.writeRegAddrW == hz.rsE);
  assign w_hit_be = w_live && (hz.writeRegAddrW == hz.rtE);

  always_comb begin
    hz.forwardAE = 2'b00;
    priority case (1'b1)
      m_hit_ae: hz.forwardAE = 2'b01;
      w_hit_ae: hz.forwardAE = 2'b10;
      default:  hz.forwardAE = 2'b00;
    endcase
  end

  always_comb begin
    hz.forwardBE = 2'b00;
    priority case (1'b1)
      m_hit_be: hz.forwardBE = 2'b01;
      w_hit_be: hz.forwardBE = 2'b10;
      default:  hz.forwardBE = 2'b00;
    endcase
  end

  assign hz.forwardAD = m_live && (hz.writeRegAddrM == hz.rsD);
  assign hz.forwardBD = m_live && (hz.writeRegAddrM == hz.rtD);

  assign lw_stall = hz.memToRegE
                 && (hz.writeRegAddrE != 5'd0)
                 && ((hz.writeRegAddrE == hz.rsD)
                  || (hz.writeRegAddrE == hz.rtD));

  assign e_hit_d = e_live
                && ((hz.writeRegAddrE == hz.rsD)
                 || (hz.writeRegAddrE == hz.rtD));

  assign m_hit_d = hz.memToRegM
                && (hz.writeRegAddrM != 5'd0)
                && ((hz.writeRegAddrM == hz.rsD)
                 || (hz.writeRegAddrM == hz.rtD));

  assign br_stall = hz.branchD && (e_hit_d || m_hit_d);

  // HI/LO is written on the DONE edge, so a read there waits a cycle
  assign md_stall = ((state == BUSY) && (hz.mdStartE || hz.mdReadE))
                 || ((state == DONE) && hz.mdReadE);

  assign hz.stallE = md_stall;
  assign hz.stallF = lw_stall || br_stall || md_stall;
  assign hz.stallD = lw_stall || br_stall || md_stall;
  assign hz.flushE = (lw_stall || br_stall) && !md_stall;

  assign ld_val = hz.mdIsDivE ? DIV_LD : MUL_LD;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (hz.mdStartE) begin
          state_n = BUSY;
          cnt_n   = ld_val;
        end
      end
      BUSY: begin
        if (cnt == '0) begin
          state_n = DONE;
        end else begin
          cnt_n = cnt - ONE;
        end
      end
      DONE: begin
        if (hz.mdStartE) begin
          state_n = BUSY;
          cnt_n   = ld_val;
        end else begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  assign hz.mdBusy  = (state == BUSY);
  assign hz.mdDone  = (state == DONE);
  assign hz.mdState = state;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: table of combinational hazard
// vectors plus hand-written mult/div sequences.
module tb_hazard_ctrl;

  logic clk;
  logic rst_n;

  hazard_ctrl_if hz ();

  hazard_ctrl #(
    .MUL_CYCLES(4),
    .DIV_CYCLES(32),
    .CNT_W(6)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .hz(hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed;
  int total;

  // flags: {rwE, rwM, rwW, mtrE, mtrM, br, mdRead}
  // exp:   {fAE[1:0], fBE[1:0], fAD, fBD, stF, stD, stE, flushE}
  typedef struct packed {
    logic [4:0] rs_d;
    logic [4:0] rt_d;
    logic [4:0] rs_e;
    logic [4:0] rt_e;
    logic [4:0] wa_e;
    logic [4:0] wa_m;
    logic [4:0] wa_w;
    logic [6:0] flags;
    logic [9:0] exp;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  function automatic vec_t mk(
    input logic [4:0] rs_d, input logic [4:0] rt_d,
    input logic [4:0] rs_e, input logic [4:0] rt_e,
    input logic [4:0] wa_e, input logic [4:0] wa_m,
    input logic [4:0] wa_w, input logic [6:0] flags,
    input logic [9:0] exp);
    vec_t v;
    v.rs_d  = rs_d;
    v.rt_d  = rt_d;
    v.rs_e  = rs_e;
    v.rt_e  = rt_e;
    v.wa_e  = wa_e;
    v.wa_m  = wa_m;
    v.wa_w  = wa_w;
    v.flags = flags;
    v.exp   = exp;
    return v;
  endfunction

  task automatic check(input string name, input int idx,
                       input logic [31:0] got,
                       input logic [31:0] want);
    total++;
    if (got === want) begin
      passed++;
    end else begin
      $display("FAIL %s[%0d]: got %0h expected %0h",
               name, idx, got, want);
    end
  endtask

  task automatic idle_inputs();
    hz.rsD = '0;
    hz.rtD = '0;
    hz.rsE = '0;
    hz.rtE = '0;
    hz.writeRegAddrE = '0;
    hz.writeRegAddrM = '0;
    hz.writeRegAddrW = '0;
    hz.regWriteE = 1'b0;
    hz.regWriteM = 1'b0;
    hz.regWriteW = 1'b0;
    hz.memToRegE = 1'b0;
    hz.memToRegM = 1'b0;
    hz.branchD   = 1'b0;
    hz.mdStartE  = 1'b0;
    hz.mdIsDivE  = 1'b0;
    hz.mdReadE   = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    hz.rsD = v.rs_d;
    hz.rtD = v.rt_d;
    hz.rsE = v.rs_e;
    hz.rtE = v.rt_e;
    hz.writeRegAddrE = v.wa_e;
    hz.writeRegAddrM = v.wa_m;
    hz.writeRegAddrW = v.wa_w;
    {hz.regWriteE, hz.regWriteM, hz.regWriteW,
     hz.memToRegE, hz.memToRegM, hz.branchD,
     hz.mdReadE} = v.flags;
  endtask

  function automatic logic [9:0] outs();
    return {hz.forwardAE, hz.forwardBE, hz.forwardAD,
            hz.forwardBD, hz.stallF, hz.stallD,
            hz.stallE, hz.flushE};
  endfunction

  // Accept one mult/div at the next posedge, then drop the request
  task automatic start_md(input logic is_div);
    @(negedge clk);
    hz.mdStartE = 1'b1;
    hz.mdIsDivE = is_div;
    @(posedge clk);
    #1;
    hz.mdStartE = 1'b0;
    hz.mdIsDivE = 1'b0;
  endtask

  task automatic run_md(input string name, input logic is_div,
                        input int n);
    start_md(is_div);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check({name, "_busy"}, i, {hz.mdBusy, hz.mdDone, hz.mdState},
            {1'b1, 1'b0, 2'b01});
    end
    @(negedge clk);
    check({name, "_done"}, n, {hz.mdBusy, hz.mdDone, hz.mdState},
          {1'b0, 1'b1, 2'b10});
    @(negedge clk);
    check({name, "_idle"}, n + 1, {hz.mdBusy, hz.mdDone, hz.mdState},
          {1'b0, 1'b0, 2'b00});
  endtask

  initial begin
    int done_seen;
    passed = 0;
    total  = 0;

    vecs[0]  = mk(0, 0, 5, 5, 0, 5, 5, 7'b0110000, 10'b0101000000);
    vecs[1]  = mk(0, 0, 5, 5, 0, 5, 5, 7'b0010000, 10'b1010000000);
    vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0, 7'b1110000, 10'b0000000000);
    vecs[3]  = mk(0, 0, 5, 6, 0, 5, 6, 7'b0110000, 10'b0110000000);
    vecs[4]  = mk(8, 0, 0, 0, 8, 0, 0, 7'b1001000, 10'b0000001101);
    vecs[5]  = mk(0, 0, 0, 0, 0, 0, 0, 7'b1001000, 10'b0000000000);
    vecs[6]  = mk(0, 8, 0, 0, 8, 0, 0, 7'b1001000, 10'b0000001101);
    vecs[7]  = mk(0, 3, 0, 0, 3, 0, 0, 7'b1000010, 10'b0000001101);
    vecs[8]  = mk(0, 3, 0, 0, 0, 3, 0, 7'b0100010, 10'b0000010000);
    vecs[9]  = mk(0, 3, 0, 0, 0, 3, 0, 7'b0100110, 10'b0000011101);
    vecs[10] = mk(0, 3, 0, 0, 3, 0, 0, 7'b1000000, 10'b0000000000);
    vecs[11] = mk(7, 0, 0, 0, 0, 7, 0, 7'b0100000, 10'b0000100000);
    vecs[12] = mk(0, 0, 0, 0, 0, 0, 0, 7'b0000001, 10'b0000000000);
    vecs[13] = mk(0, 0, 0, 0, 0, 0, 0, 7'b1100010, 10'b0000000000);
    vecs[14] = mk(4, 0, 0, 0, 0, 4, 0, 7'b0100100, 10'b0000100000);

    idle_inputs();
    rst_n = 1'b0;
    #12;
    check("reset_state", 0, {hz.mdBusy, hz.mdDone, hz.mdState}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      #1;
      apply(vecs[i]);
      @(negedge clk);
      check("vec", i, 32'(outs()), 32'(vecs[i].exp));
    end
    @(posedge clk);
    #1;
    idle_inputs();

    run_md("mul", 1'b0, 4);
    run_md("div", 1'b0 | 1'b1, 32);

    // mfhi/mflo held in EX behind a multiply
    start_md(1'b0);
    hz.mdReadE = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rd_stall", i,
            {hz.stallE, hz.stallF, hz.stallD, hz.flushE}, 4'b1110);
    end
    @(negedge clk);
    check("rd_release", 0,
          {hz.mdState, hz.stallE, hz.stallF, hz.stallD, hz.flushE},
          6'b000000);
    @(posedge clk);
    #1;
    hz.mdReadE = 1'b0;

    // back-to-back: second op waits in EX, accepted in DONE
    @(negedge clk);
    hz.mdStartE = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("b2b_hold", i, {hz.mdState, hz.stallE}, 3'b011);
    end
    @(negedge clk);
    check("b2b_done", 0, {hz.mdState, hz.mdDone, hz.stallE}, 4'b1010);
    @(posedge clk);
    #1;
    hz.mdStartE = 1'b0;
    @(negedge clk);
    check("b2b_rebusy", 0, {hz.mdState, hz.mdBusy}, 3'b011);
    repeat (6) @(negedge clk);
    check("b2b_idle", 0, {hz.mdState, hz.mdDone}, 3'b000);

    // asynchronous reset part-way through a divide
    start_md(1'b1);
    repeat (14) @(posedge clk);
    #2;
    check("pre_rst", 0, {hz.mdBusy, hz.mdState}, 3'b101);
    rst_n = 1'b0;
    #1;
    check("async_rst", 0, {hz.mdBusy, hz.mdDone, hz.mdState}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (hz.mdDone || hz.mdBusy) done_seen++;
    end
    check("no_done_after_rst", 0, 32'(done_seen), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
